vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Timing source for the VGA text path: divides clk into a pixel-rate enable and scans
//  pixel_x/pixel_y over a full 800x525 frame. Drives hsync/vsync to the connector and
//  pixel_x, pixel_y, video_on to the text renderer, which turns coordinates into rgb_text.
//  An optional delay line shifts hsync/vsync/video_on to match downstream pipeline latency.
// PARAMETERS
//  CLK_DIV     2    clk cycles per pixel; legal range >=1 (2: 50 MHz -> 25 MHz)
//  H_DISPLAY   640  visible pixels per line
//  H_FRONT     16   horizontal front porch, pixels
//  H_SYNC      96   hsync pulse width, pixels
//  H_BACK      48   horizontal back porch, pixels
//  V_DISPLAY   480  visible lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vsync pulse width, lines
//  V_BACK      33   vertical back porch, lines
//  H_POL       0    hsync active level (0 = active-low)
//  V_POL       0    vsync active level (0 = active-low)
//  SYNC_DELAY  0    pixel ticks of delay on hsync/vsync/video_on; legal range 0..3
// PORTS
//  clk          in   1   system clock; the only clock
//  reset_n      in   1   synchronous active-low reset
//  pixel_tick   out  1   one-clk pulse per pixel period; counters advance on it
//  pixel_x      out  10  horizontal position, 0..H_TOTAL-1
//  pixel_y      out  10  vertical position, 0..V_TOTAL-1
//  video_on     out  1   1 while pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
//  hsync        out  1   horizontal sync, polarity set by H_POL
//  vsync        out  1   vertical sync, polarity set by V_POL
//  line_start   out  1   one-clk pulse on the tick where pixel_x wraps to 0
//  frame_start  out  1   one-clk pulse on the tick where pixel_x and pixel_y both wrap to 0
// BEHAVIOUR
//  Clocking and reset: one clock domain (clk). reset_n is synchronous and active-low.
//  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = sum of the V_* timings (525).
//  - Reset (reset_n=0 at a clk edge): div_cnt=0, pixel_x=0, pixel_y=0, pixel_tick=0.
//    In the same edge: video_on=0, hsync=!H_POL, vsync=!V_POL, line_start=0, frame_start=0.
//    All delay-line stages clear to the same inactive values.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pixel_tick=1 (combinational from
//    div_cnt) when div_cnt==CLK_DIV-1. With CLK_DIV=1, pixel_tick is constantly 1 out of reset.
//  - On an edge where pixel_tick=1: if pixel_x==H_TOTAL-1, pixel_x<=0; otherwise pixel_x+1.
//    When pixel_x wraps, pixel_y advances: pixel_y==V_TOTAL-1 ? 0 : pixel_y+1.
//    pixel_y changes only when pixel_x wraps; no other path changes it.
//  - Decode is registered and computed from the counters' next-state values, so it changes
//    on the same edge as pixel_x/pixel_y (zero skew, glitch-free):
//    - video_on: next_x<H_DISPLAY and next_y<V_DISPLAY.
//    - hsync active: H_DISPLAY+H_FRONT <= next_x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//    - vsync active: V_DISPLAY+V_FRONT <= next_y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
//    - First edge after reset release: counters hold at (0,0) unless pixel_tick; video_on->1.
//  - line_start: 1 for exactly the one clk after the edge where pixel_x wrapped to 0.
//    frame_start: the same, when pixel_y also wrapped to 0. Neither pulses on reset release.
//  - Delay line: hsync, vsync and video_on pass through SYNC_DELAY stages that shift only when
//    pixel_tick=1. SYNC_DELAY=0 is a wire. pixel_x, pixel_y, line_start and frame_start are
//    never delayed.
//  - Downstream contract: the font ROM is synchronous with 1-clk latency, and rgb_text is
//    combinational. With CLK_DIV>=2, rgb_text settles within the same pixel period, so 0 is
//    the required setting there.
//  - Reset mid-frame: all state returns to the reset values on the next edge; the frame
//    restarts at (0,0). No partial sync pulse is extended.
//  - Counter widths: 10 bits, sufficient for H_TOTAL and V_TOTAL <= 1024. Counters never
//    exceed TOTAL-1.
// TESTING
//  1 Reset with reset_n=0 for 3 clks, then release -> pixel_x=0, pixel_y=0, hsync=vsync=1,
//    video_on=0 during reset, video_on=1 one clk after release; pixel_tick every 2nd clk.
//  2 Run one line -> video_on falls at x=640, hsync low for x=656..751 (96 ticks),
//    x wraps 799->0, y 0->1, line_start pulses once (1 clk).
//  3 Run full frame -> vsync low exactly for y=490..491; y wraps 524->0 with frame_start
//    1 clk; frame = 420000 ticks = 840000 clks at CLK_DIV=2.
//  4 Drop reset_n for 1 clk at x=700,y=490 (both syncs active) -> next edge hsync=vsync=1,
//    x=y=0; frame restarts without a glitch.
//  5 SYNC_DELAY=2 -> hsync falls at tick of x=658, video_on falls at x=642;
//    pixel_x timing is unchanged versus scenario 2.
//  6 CLK_DIV=1, H_DISPLAY=8, H_FRONT=H_SYNC=H_BACK=2, V_*=2 -> line of 14 clks;
//    pixel_tick constant 1; all decode windows match the formulas above.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, x/y scan counters, registered
// sync/blank decode and an optional tick-aligned delay line on the sync outputs.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned H_POL      = 0,
    parameter int unsigned V_POL      = 0,
    parameter int unsigned SYNC_DELAY = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic             HS_ACTIVE  = 1'(H_POL);
    localparam logic             VS_ACTIVE  = 1'(V_POL);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             run_q;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             x_wrap;
    logic             von_q, von_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    // run_q keeps the enable low while in reset so CLK_DIV=1 cannot tick early
    assign pixel_tick = run_q && (div_cnt_q == DIV_LAST);

    // Next-state for divider, counters, and decode taken from the next counter values
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        x_wrap    = pixel_tick && (x_q == H_LAST);
        x_d       = x_q;
        y_d       = y_q;
        if (pixel_tick) begin
            x_d = x_wrap ? '0 : x_q + CNT_W'(1);
        end
        if (x_wrap) begin
            y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
        end
        von_d = (x_d < H_VIS_END) && (y_d < V_VIS_END);
        hs_d  = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_ACTIVE : ~HS_ACTIVE;
        vs_d  = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_ACTIVE : ~VS_ACTIVE;
        ls_d  = x_wrap;
        fs_d  = x_wrap && (y_q == V_LAST);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            run_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            von_q     <= 1'b0;
            hs_q      <= ~HS_ACTIVE;
            vs_q      <= ~VS_ACTIVE;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            run_q     <= 1'b1;
            x_q       <= x_d;
            y_q       <= y_d;
            von_q     <= von_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign video_on = von_q;
            assign hsync    = hs_q;
            assign vsync    = vs_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] von_dly_q;
            logic [SYNC_DELAY-1:0] hs_dly_q;
            logic [SYNC_DELAY-1:0] vs_dly_q;

            // Tick-aligned shift line matching downstream pixel pipeline latency
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    von_dly_q <= '0;
                    hs_dly_q  <= {SYNC_DELAY{~HS_ACTIVE}};
                    vs_dly_q  <= {SYNC_DELAY{~VS_ACTIVE}};
                end else if (pixel_tick) begin
                    von_dly_q[0] <= von_q;
                    hs_dly_q[0]  <= hs_q;
                    vs_dly_q[0]  <= vs_q;
                    for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                        von_dly_q[i] <= von_dly_q[i-1];
                        hs_dly_q[i]  <= hs_dly_q[i-1];
                        vs_dly_q[i]  <= vs_dly_q[i-1];
                    end
                end
            end

            assign video_on = von_dly_q[SYNC_DELAY-1];
            assign hsync    = hs_dly_q[SYNC_DELAY-1];
            assign vsync    = vs_dly_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three configurations checked every clock
// against a position-index reference model.
module tb_vga_sync_gen;

    typedef struct {
        int cd, hd, hf, hs, hb, vd, vf, vs, vb, hpol, vpol, dly;
    } pcfg_t;

    typedef struct {
        int         inst;
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

    localparam int N_CYC = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic       tk [3];
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       von [3];
    logic       hs [3];
    logic       vs [3];
    logic       ls [3];
    logic       fs [3];

    int   n_checks = 0;
    int   n_pass = 0;
    int   e_cnt [3];
    int   n_cnt [3];
    exp_t sb_q [$];
    bit   mid_reset_done = 0;

    always #5 clk = ~clk;

    // A: default timing with a 2-tick sync delay
    vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
                   .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
                   .H_POL(0), .V_POL(0), .SYNC_DELAY(2)) u_dut_a (
        .clk(clk), .reset_n(rst_n), .pixel_tick(tk[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .video_on(von[0]), .hsync(hs[0]), .vsync(vs[0]),
        .line_start(ls[0]), .frame_start(fs[0]));

    // B: tiny timing, CLK_DIV=1, positive hsync, delay 2, own reset for mid-frame drop
    vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_DISPLAY(2), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
                   .H_POL(1), .V_POL(0), .SYNC_DELAY(2)) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .pixel_tick(tk[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .video_on(von[1]), .hsync(hs[1]), .vsync(vs[1]),
        .line_start(ls[1]), .frame_start(fs[1]));

    // C: small full frames at CLK_DIV=2, positive vsync, no delay
    vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
                   .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .H_POL(0), .V_POL(1), .SYNC_DELAY(0)) u_dut_c (
        .clk(clk), .reset_n(rst_n), .pixel_tick(tk[2]), .pixel_x(px[2]), .pixel_y(py[2]),
        .video_on(von[2]), .hsync(hs[2]), .vsync(vs[2]),
        .line_start(ls[2]), .frame_start(fs[2]));

    function automatic pcfg_t get_cfg(input int i);
        pcfg_t c;
        case (i)
            0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
            1:       c = '{1, 8, 2, 2, 2, 2, 2, 2, 2, 1, 0, 2};
            default: c = '{2, 16, 4, 6, 4, 8, 2, 2, 3, 0, 1, 0};
        endcase
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Decode of a linear pixel index into blank/sync levels
    task automatic decode(input pcfg_t c, input int p, output logic v, output logic h,
                          output logic s);
        int ht, vt, xx, yy;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        xx = p % ht;
        yy = (p / ht) % vt;
        v  = (xx < c.hd) && (yy < c.vd);
        h  = ((xx >= c.hd + c.hf) && (xx < c.hd + c.hf + c.hs)) ? 1'(c.hpol) : ~1'(c.hpol);
        s  = ((yy >= c.vd + c.vf) && (yy < c.vd + c.vf + c.vs)) ? 1'(c.vpol) : ~1'(c.vpol);
    endtask

    // Predict outputs after the coming edge given the reset level driven for it
    task automatic model_step(input int i, input logic rst, output exp_t ex);
        pcfg_t c;
        int    ht, vt;
        logic  tick_before;
        c = get_cfg(i);
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        ex.inst = i;
        if (!rst) begin
            e_cnt[i] = 0;
            n_cnt[i] = 0;
            ex.tick = 1'b0; ex.x = '0; ex.y = '0; ex.von = 1'b0;
            ex.hs = ~1'(c.hpol); ex.vs = ~1'(c.vpol); ex.ls = 1'b0; ex.fs = 1'b0;
        end else begin
            tick_before = (e_cnt[i] >= 1) && (e_cnt[i] % c.cd == c.cd - 1);
            if (tick_before) n_cnt[i]++;
            e_cnt[i]++;
            ex.tick = (e_cnt[i] % c.cd == c.cd - 1);
            ex.x    = 10'(n_cnt[i] % ht);
            ex.y    = 10'((n_cnt[i] / ht) % vt);
            ex.ls   = tick_before && (n_cnt[i] % ht == 0);
            ex.fs   = tick_before && (n_cnt[i] % (ht * vt) == 0);
            if (n_cnt[i] < c.dly) begin
                ex.von = 1'b0; ex.hs = ~1'(c.hpol); ex.vs = ~1'(c.vpol);
            end else begin
                decode(c, n_cnt[i] - c.dly, ex.von, ex.hs, ex.vs);
            end
        end
    endtask

    task automatic compare_one(input exp_t ex, input int cyc);
        string nm;
        nm = $sformatf("dut%0d.c%0d", ex.inst, cyc);
        check_eq({nm, ".pixel_tick"},  10'(tk[ex.inst]),  10'(ex.tick));
        check_eq({nm, ".pixel_x"},     px[ex.inst],       ex.x);
        check_eq({nm, ".pixel_y"},     py[ex.inst],       ex.y);
        check_eq({nm, ".video_on"},    10'(von[ex.inst]), 10'(ex.von));
        check_eq({nm, ".hsync"},       10'(hs[ex.inst]),  10'(ex.hs));
        check_eq({nm, ".vsync"},       10'(vs[ex.inst]),  10'(ex.vs));
        check_eq({nm, ".line_start"},  10'(ls[ex.inst]),  10'(ex.ls));
        check_eq({nm, ".frame_start"}, 10'(fs[ex.inst]),  10'(ex.fs));
    endtask

    initial begin
        exp_t ex;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            rst_n   = (cyc >= 3);
            rst_b_n = (cyc >= 3);
            // Drop B's reset for one clk while both its syncs are asserted mid-frame
            if (!mid_reset_done && cyc > 300 && px[1] == 10'd11 && py[1] == 10'd4) begin
                rst_b_n = 1'b0;
                mid_reset_done = 1;
            end
            model_step(0, rst_n, ex);   sb_q.push_back(ex);
            model_step(1, rst_b_n, ex); sb_q.push_back(ex);
            model_step(2, rst_n, ex);   sb_q.push_back(ex);
            @(posedge clk);
            #1;
            while (sb_q.size() > 0) begin
                ex = sb_q.pop_front();
                compare_one(ex, cyc);
            end
        end
        n_checks++;
        if (mid_reset_done) n_pass++;
        else $display("FAIL mid_frame_reset: got not applied expected applied");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
